canvas_write_ctrl: RTL

//  Writer side of the handwriting canvas BRAM; the VGA pixel generator reads it back.

---
 rtl/canvas_write_ctrl_if.sv | 47 ++++
 rtl/canvas_write_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/canvas_write_ctrl_if.sv
// Bus bundle between the canvas write controller and its surroundings:
// mouse/draw inputs on one side, BRAM port A and status on the other.
interface canvas_write_ctrl_if #(
  parameter int ADDR_W = 10
);
  // Drawing control and cursor inputs
  logic              enable;
  logic              MOUSE_LEFT;
  logic [9:0]        mouse_x;
  logic [9:0]        mouse_y;
  logic              clear_req;

  // BRAM port A and status outputs
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_din;
  logic              busy;
  logic              clear_done;

  // Controller side: consumes cursor/button, drives the BRAM port
  modport master (
    input  enable,
    input  MOUSE_LEFT,
    input  mouse_x,
    input  mouse_y,
    input  clear_req,
    output mem_we,
    output mem_addr,
    output mem_din,
    output busy,
    output clear_done
  );

  // Environment side: supplies cursor/button, observes the BRAM port
  modport slave (
    output enable,
    output MOUSE_LEFT,
    output mouse_x,
    output mouse_y,
    output clear_req,
    input  mem_we,
    input  mem_addr,
    input  mem_din,
    input  busy,
    input  clear_done
  );
endinterface

// File: rtl/canvas_write_ctrl.sv
// Writer side of the handwriting canvas BRAM. Turns the mouse cursor and
// left button into 1-bit ink writes with a 2x2-cell brush, skips repeat
// writes into the cell last painted, and sweeps the whole canvas to blank
// on a clear request. All bus outputs are registered.
module canvas_write_ctrl #(
  parameter int CANVAS_X0 = 208,
  parameter int CANVAS_Y0 = 128,
  parameter int GRID_W    = 28,
  parameter int GRID_H    = 28,
  parameter int SCALE_SH  = 3,
  parameter int ADDR_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  canvas_write_ctrl_if.master   bus
);

  // Canvas extents in screen pixels and the last cell address of the grid
  localparam int CANVAS_W = GRID_W << SCALE_SH;
  localparam int CANVAS_H = GRID_H << SCALE_SH;
  localparam int CELLS    = GRID_W * GRID_H;

  localparam logic [10:0] X_LO = 11'(CANVAS_X0);
  localparam logic [10:0] X_HI = 11'(CANVAS_X0 + CANVAS_W);
  localparam logic [10:0] Y_LO = 11'(CANVAS_Y0);
  localparam logic [10:0] Y_HI = 11'(CANVAS_Y0 + CANVAS_H);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PAINT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // Brush slot k covers (col + k[0], row + k[1]). Returns {in_grid, addr};
  // slots falling off the right or bottom edge come back with in_grid = 0.
  function automatic logic [ADDR_W:0] brush_slot(
    input logic [9:0] c0,
    input logic [9:0] r0,
    input logic [1:0] slot
  );
    logic [10:0]       c;
    logic [10:0]       r;
    logic              ok;
    logic [ADDR_W-1:0] lin;
    c   = {1'b0, c0} + {10'd0, slot[0]};
    r   = {1'b0, r0} + {10'd0, slot[1]};
    ok  = (c < 11'(GRID_W)) && (r < 11'(GRID_H));
    lin = ADDR_W'(({11'd0, r} * 22'(GRID_W)) + {11'd0, c});
    return {ok, lin};
  endfunction

  // Registered state
  logic [1:0]        state_r;
  logic [1:0]        slot_r;
  logic [9:0]        cell_col_r;
  logic [9:0]        cell_row_r;
  logic [9:0]        last_col_r;
  logic [9:0]        last_row_r;
  logic              last_valid_r;
  logic              clr_pend_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_din_r;
  logic              busy_r;
  logic              clear_done_r;

  // Hit test and cell decode (full width, no wrap)
  logic [10:0]       x_ext_s;
  logic [10:0]       y_ext_s;
  logic [10:0]       dx_s;
  logic [10:0]       dy_s;
  logic              inside_s;
  logic [9:0]        hit_col_s;
  logic [9:0]        hit_row_s;
  logic              same_cell_s;
  logic              start_paint_s;
  logic              start_clear_s;
  logic [ADDR_W:0]   first_slot_s;
  logic [ADDR_W:0]   next_slot_s;
  logic [1:0]        slot_inc_s;

  assign x_ext_s   = {1'b0, bus.mouse_x};
  assign y_ext_s   = {1'b0, bus.mouse_y};
  assign dx_s      = x_ext_s - X_LO;
  assign dy_s      = y_ext_s - Y_LO;
  assign inside_s  = (x_ext_s >= X_LO) && (x_ext_s < X_HI) &&
                     (y_ext_s >= Y_LO) && (y_ext_s < Y_HI);
  assign hit_col_s = 10'(dx_s >> SCALE_SH);
  assign hit_row_s = 10'(dy_s >> SCALE_SH);

  // A held button that stays in the cell just painted must not repaint it
  assign same_cell_s   = last_valid_r && (hit_col_s == last_col_r) &&
                         (hit_row_s == last_row_r);
  assign start_paint_s = bus.enable && bus.MOUSE_LEFT && inside_s && !same_cell_s;
  assign start_clear_s = bus.clear_req || clr_pend_r;

  // Slot 0 comes from the live cursor; later slots from the latched cell
  assign slot_inc_s   = slot_r + 2'd1;
  assign first_slot_s = brush_slot(hit_col_s, hit_row_s, 2'd0);
  assign next_slot_s  = brush_slot(cell_col_r, cell_row_r, slot_inc_s);

  // Main controller: state, brush sequencing, clear sweep and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      slot_r       <= 2'd0;
      cell_col_r   <= 10'd0;
      cell_row_r   <= 10'd0;
      last_col_r   <= 10'd0;
      last_row_r   <= 10'd0;
      last_valid_r <= 1'b0;
      clr_pend_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_din_r    <= 1'b0;
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      clear_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!bus.MOUSE_LEFT) begin
            last_valid_r <= 1'b0;
          end
          if (start_clear_s) begin
            // Clear wins over painting; first blank write goes out now
            state_r    <= ST_CLEAR;
            clr_pend_r <= 1'b0;
            busy_r     <= 1'b1;
            mem_we_r   <= 1'b1;
            mem_din_r  <= 1'b0;
            mem_addr_r <= '0;
          end else if (start_paint_s) begin
            state_r      <= ST_PAINT;
            slot_r       <= 2'd0;
            cell_col_r   <= hit_col_s;
            cell_row_r   <= hit_row_s;
            last_col_r   <= hit_col_s;
            last_row_r   <= hit_row_s;
            last_valid_r <= 1'b1;
            busy_r       <= 1'b1;
            mem_we_r     <= first_slot_s[ADDR_W];
            mem_din_r    <= 1'b1;
            mem_addr_r   <= first_slot_s[ADDR_W-1:0];
          end else begin
            busy_r     <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_din_r  <= 1'b0;
            mem_addr_r <= '0;
          end
        end

        ST_PAINT: begin
          // A clear arriving mid-brush is remembered, never dropped
          if (bus.clear_req) begin
            clr_pend_r <= 1'b1;
          end
          if (slot_r == 2'd3) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_din_r  <= 1'b0;
            mem_addr_r <= '0;
          end else begin
            // Off-grid slots still take their cycle, just with we low
            slot_r     <= slot_inc_s;
            mem_we_r   <= next_slot_s[ADDR_W];
            mem_din_r  <= 1'b1;
            mem_addr_r <= next_slot_s[ADDR_W-1:0];
          end
        end

        ST_CLEAR: begin
          // The output address doubles as the sweep counter
          if (mem_addr_r == LAST_ADDR) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_din_r    <= 1'b0;
            mem_addr_r   <= '0;
            clear_done_r <= 1'b1;
            last_valid_r <= 1'b0;
          end else begin
            mem_we_r   <= 1'b1;
            mem_din_r  <= 1'b0;
            mem_addr_r <= mem_addr_r + ADDR_W'(1);
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          mem_we_r   <= 1'b0;
          mem_din_r  <= 1'b0;
          mem_addr_r <= '0;
        end
      endcase
    end
  end

  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_din    = mem_din_r;
  assign bus.busy       = busy_r;
  assign bus.clear_done = clear_done_r;

endmodule
